// File: rtl/cos_dp.sv
// Datapath for an iterative cosine series evaluator: shared Q2.14 multiplier,
// term/coefficient sequencing registers and the series accumulator R.
module cos_dp #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Xin,
    input  logic [7:0]        Yin,
    input  logic              cen,
    input  logic              ldseri,
    input  logic              init_temp,
    input  logic              initseri,
    input  logic              izcounter,
    input  logic              clr,
    input  logic              ld_y,
    input  logic              ldx2,
    input  logic              slx,
    input  logic              slx2,
    input  logic              slR,
    input  logic              ldtemp,
    input  logic              sltemp,
    output logic [DATA_W-1:0] ans,
    output logic              Tsignal,
    output logic              co,
    output logic              ygt_temp
);

    localparam logic [DATA_W-1:0] ONE_Q14 = DATA_W'(16'h4000);

    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] temp;
    logic [DATA_W-1:0] r;
    logic [7:0]        y;
    logic [2:0]        cnt;

    logic [DATA_W-1:0] mul_a;
    logic [COEF_W-1:0] mul_b;
    logic [COEF_W-1:0] coef;
    logic [DATA_W-1:0] product;

    // Q2.14 x Q2.14 -> Q2.14: drop 14 fraction bits, keep the next 16 (truncate, no saturation)
    function automatic logic [DATA_W-1:0] trunc_q14(input logic [DATA_W+COEF_W-1:0] full);
        return full[DATA_W+13:14];
    endfunction

    // 1/((2n-1)(2n)) in Q2.14, indexed by term number
    always_comb begin
        coef = '0;
        case (cnt)
            3'd0: coef = COEF_W'(16'h4000);
            3'd1: coef = COEF_W'(16'h2000);
            3'd2: coef = COEF_W'(16'h0555);
            3'd3: coef = COEF_W'(16'h0222);
            3'd4: coef = COEF_W'(16'h0124);
            3'd5: coef = COEF_W'(16'h00B6);
            3'd6: coef = COEF_W'(16'h007C);
            3'd7: coef = COEF_W'(16'h005A);
            default: coef = '0;
        endcase
    end

    always_comb begin
        mul_a   = slx ? Xin : temp;
        mul_b   = slx ? COEF_W'(Xin) : (slx2 ? COEF_W'(x2) : coef);
        product = trunc_q14(DATA_W'(0) + COEF_W'(0) + (DATA_W+COEF_W)'(mul_a) * (DATA_W+COEF_W)'(mul_b));
    end

    assign Tsignal  = cnt[0];
    assign co       = (cnt == 3'b111);
    assign ans      = r;
    assign ygt_temp = ({{(DATA_W-8){1'b0}}, y} > temp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x2 <= '0;
            y  <= '0;
        end else if (clr) begin
            x2 <= '0;
            y  <= '0;
        end else begin
            if (ldx2) x2 <= product;
            if (ld_y) y  <= Yin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            temp <= '0;
        else if (init_temp) temp <= ONE_Q14;
        else if (ldtemp)    temp <= sltemp ? product : Xin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (izcounter) cnt <= '0;
        else if (cen)       cnt <= cnt + 3'd1;
    end

    // Odd terms of the cosine series are subtracted; sums wrap modulo 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r <= '0;
        else if (initseri)    r <= '0;
        else if (ldseri) begin
            if (!slR)         r <= temp;
            else if (Tsignal) r <= r - temp;
            else              r <= r + temp;
        end
    end

endmodule

// File: tb/tb_cos_dp.sv
// Scoreboard bench for cos_dp: stimulus queues expected register/output values,
// a negedge monitor pops and compares them.
module tb_cos_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Xin;
    logic [7:0]  Yin;
    logic        cen, ldseri, init_temp, initseri, izcounter, clr;
    logic        ld_y, ldx2, slx, slx2, slR, ldtemp, sltemp;
    logic [15:0] ans;
    logic        Tsignal, co, ygt_temp;

    localparam int S_ANS = 0, S_CO = 1, S_TS = 2, S_YGT = 3, S_X2 = 4, S_TEMP = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    cos_dp dut (
        .clk(clk), .rst(rst), .Xin(Xin), .Yin(Yin), .cen(cen), .ldseri(ldseri),
        .init_temp(init_temp), .initseri(initseri), .izcounter(izcounter), .clr(clr),
        .ld_y(ld_y), .ldx2(ldx2), .slx(slx), .slx2(slx2), .slR(slR), .ldtemp(ldtemp),
        .sltemp(sltemp), .ans(ans), .Tsignal(Tsignal), .co(co), .ygt_temp(ygt_temp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.sel)
                S_ANS:   act = ans;
                S_CO:    act = {15'd0, co};
                S_TS:    act = {15'd0, Tsignal};
                S_YGT:   act = {15'd0, ygt_temp};
                S_X2:    act = dut.x2;
                default: act = dut.temp;
            endcase
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic idle();
        cen = 0; ldseri = 0; init_temp = 0; initseri = 0; izcounter = 0; clr = 0;
        ld_y = 0; ldx2 = 0; slx = 0; slx2 = 0; slR = 0; ldtemp = 0; sltemp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1; Xin = 16'h1357; Yin = 8'h00;
        expect_val("rst_ans", S_ANS, 16'h0000);
        expect_val("rst_co", S_CO, 16'h0);
        expect_val("rst_ts", S_TS, 16'h0);
        expect_val("rst_ygt", S_YGT, 16'h0);
        expect_val("rst_x2", S_X2, 16'h0000);
        expect_val("rst_temp", S_TEMP, 16'h0000);
        step(); step();
        rst = 0;

        // Squaring into x2
        Xin = 16'h4000; slx = 1; ldx2 = 1; step();
        expect_val("x2_one", S_X2, 16'h4000);
        Xin = 16'h0020; step();
        expect_val("x2_trunc", S_X2, 16'h0000);
        Xin = 16'h6000; step();
        expect_val("x2_1p5sq", S_X2, 16'h9000);
        Xin = 16'h4000; step();
        expect_val("x2_reload", S_X2, 16'h4000);
        idle();

        // temp = 1.0, then temp*x2, then temp*coef[1]
        init_temp = 1; step(); idle();
        expect_val("temp_init", S_TEMP, 16'h4000);
        slx2 = 1; sltemp = 1; ldtemp = 1; step(); idle();
        expect_val("temp_x2", S_TEMP, 16'h4000);
        cen = 1; step(); idle();
        expect_val("cnt1_ts", S_TS, 16'h1);
        sltemp = 1; ldtemp = 1; step(); idle();
        expect_val("temp_coef1", S_TEMP, 16'h2000);

        // Series accumulation
        izcounter = 1; init_temp = 1; initseri = 1; step(); idle();
        expect_val("acc_clr", S_ANS, 16'h0000);
        expect_val("acc_clr_ts", S_TS, 16'h0);
        ldseri = 1; slR = 1; step(); idle();
        expect_val("acc_add", S_ANS, 16'h4000);
        cen = 1; step(); idle();
        sltemp = 1; ldtemp = 1; step(); idle();
        expect_val("acc_temp", S_TEMP, 16'h2000);
        ldseri = 1; slR = 1; step(); idle();
        expect_val("acc_sub", S_ANS, 16'h2000);
        Xin = 16'h1234; ldtemp = 1; step(); idle();
        ldseri = 1; step(); idle();
        expect_val("acc_load", S_ANS, 16'h1234);
        Xin = 16'h2000; ldtemp = 1; step(); idle();
        ldseri = 1; slR = 1; step(); idle();
        expect_val("acc_wrap", S_ANS, 16'hF234);

        // Clear/init controls beat loads in the same cycle
        initseri = 1; ldseri = 1; slR = 1; Xin = 16'h0111; init_temp = 1; ldtemp = 1;
        clr = 1; slx = 1; ldx2 = 1; izcounter = 1; cen = 1; step(); idle();
        expect_val("pri_r", S_ANS, 16'h0000);
        expect_val("pri_temp", S_TEMP, 16'h4000);
        expect_val("pri_x2", S_X2, 16'h0000);
        expect_val("pri_ts", S_TS, 16'h0);

        // Counter terminal count and wrap
        izcounter = 1; step(); idle();
        expect_val("cnt0_co", S_CO, 16'h0);
        for (int k = 1; k <= 8; k++) begin
            cen = 1; step();
            expect_val($sformatf("cnt%0d_co", k % 8), S_CO, (k == 7) ? 16'h1 : 16'h0);
            expect_val($sformatf("cnt%0d_ts", k % 8), S_TS, 16'(k % 2));
        end
        idle();

        // Threshold comparison
        Yin = 8'h10; ld_y = 1; Xin = 16'h000F; ldtemp = 1; step(); idle();
        expect_val("ygt_f", S_YGT, 16'h1);
        Xin = 16'h0010; ldtemp = 1; step(); idle();
        expect_val("ygt_eq", S_YGT, 16'h0);
        Xin = 16'h0008; ldtemp = 1; clr = 1; step(); idle();
        expect_val("ygt_clr", S_YGT, 16'h0);

        // Asynchronous reset mid-run
        slx = 1; ldx2 = 1; Xin = 16'h4000; init_temp = 1; cen = 1; ldseri = 1; step(); idle();
        expect_val("pre_rst_ans", S_ANS, 16'h0008);
        @(posedge clk); #2;
        rst = 1; #1;
        expect_val("arst_ans", S_ANS, 16'h0000);
        expect_val("arst_x2", S_X2, 16'h0000);
        expect_val("arst_temp", S_TEMP, 16'h0000);
        expect_val("arst_ts", S_TS, 16'h0);
        step();
        rst = 0;
        cen = 1; step(); idle();
        expect_val("post_rst_ts", S_TS, 16'h1);

        step(); step();
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cos_dp.md
COS_DP -- requirements
Module: cos_dp

Interface
REQ-001 clk  in  1  sole clock; all registers update on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 Xin  in  16  operand x, unsigned Q2.14 (0x4000 = 1.0).
REQ-004 Yin  in  8  precision threshold, compared against LSBs of temp.
REQ-005 Tsignal  out  1  sign of current term, equal to cnt[0] (1 = subtract).
REQ-006 cen  in  1  term-counter increment enable.
REQ-007 ldseri  in  1  load/accumulate series register R.
REQ-008 init_temp  in  1  set temp to 1.0 (0x4000).
REQ-009 initseri  in  1  clear R to 0.
REQ-010 izcounter  in  1  clear term counter.
REQ-011 clr  in  1  clear y and x2 registers.
REQ-012 ld_y  in  1  load y <= Yin.
REQ-013 ldx2  in  1  load x2 <= product.
REQ-014 slx  in  1  multiplier operands both Xin (squaring).
REQ-015 slx2  in  1  when slx=0, operand B = x2 (else coefficient ROM).
REQ-016 slR  in  1  1: R accumulates ±temp; 0: R loads temp directly.
REQ-017 ldtemp  in  1  load temp register.
REQ-018 sltemp  in  1  temp source: 1 = product, 0 = Xin.
REQ-019 ans  out  16  R register, Q2.14.
REQ-020 co  out  1  counter terminal count, high when cnt == 3'b111.
REQ-021 ygt_temp  out  1  combinational ({8'h00,y} > temp), unsigned.

Function
REQ-022 Registers: x2[15:0], temp[15:0], R[15:0], y[7:0], cnt[2:0].
REQ-023 Multiplier shared, combinational: A = slx ? Xin : temp; B = slx ? Xin : (slx2 ? x2 : coef); P = (A*B)[29:14] (32-bit product, shifted right 14, truncated).
REQ-024 Coefficient ROM indexed by cnt, value 1/((2n-1)(2n)) in Q2.14 truncated: 0:0x4000, 1:0x2000, 2:0x0555, 3:0x0222, 4:0x0124, 5:0x00B6, 6:0x007C, 7:0x005A.
REQ-025 temp: init_temp -> 0x4000; else ldtemp -> (sltemp ? P : Xin); else hold.
REQ-026 x2/y: clr -> 0 (both); else ldx2 -> x2<=P, ld_y -> y<=Yin independently.
REQ-027 cnt: izcounter -> 0; else cen -> cnt+1, wrapping 7->0; co reflects current cnt.
REQ-028 R: initseri -> 0; else ldseri & slR -> R + temp (Tsignal=0) or R - temp (Tsignal=1), modulo 2^16; else ldseri & ~slR -> temp.
REQ-029 Priority in same cycle: rst > init/clear controls > load/enable controls.
REQ-030 Outputs ans, co, Tsignal, ygt_temp are functions of current register state (no added latency); loads visible one cycle after the enabling edge.
REQ-031 No internal FSM; sequencing (temp*x2 then temp*coef, accumulate, cen, stop on co or ygt_temp) is controller responsibility.

Reset
REQ-032 rst high clears x2, temp, R, y, cnt to 0 immediately, independent of clk; thus ans=0, co=0, Tsignal=0, ygt_temp=0.
REQ-033 Reset mid-operation discards all state; first edge after release obeys REQ-025..028.

Verification
REQ-034 Reset pulse mid-run -> all registers 0 asynchronously, ans=0x0000.
REQ-035 Xin=0x4000, slx=1, ldx2=1 -> x2=0x4000; Xin=0x0020 -> x2=0x0000 (truncation).
REQ-036 init_temp, then slx2=1, sltemp=1, ldtemp=1 with x2=0x4000 -> temp stays 0x4000; then cnt=1, slx2=0 -> temp=0x2000.
REQ-037 initseri, ldseri&slR with temp=0x4000, cnt=0 -> ans=0x4000; cen; temp=0x2000 -> ans=0x2000 (subtract, Tsignal=1).
REQ-038 cen held 8 cycles from 0 -> co high only at cnt=7, then wraps to 0.
REQ-039 ld_y with Yin=0x10: temp=0x000F -> ygt_temp=1; temp=0x0010 -> ygt_temp=0.
